jk_flip_flop: RTL and testbench



---
 rtl/jk_flip_flop_pkg.sv | 24 ++
 rtl/jk_flip_flop_bit.sv | 29 ++
 rtl/jk_flip_flop.sv | 42 ++++
 tb/tb_jk_flip_flop.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/jk_flip_flop_pkg.sv
// rtl/jk_flip_flop_pkg.sv - JK mode encoding and next-state function shared by RTL and bench
package jk_ff_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_mode_t;

  function automatic logic next_q(input jk_mode_t mode, input logic q);
    logic w_next;
    w_next = q;
    case (mode)
      JK_HOLD:   w_next = q;
      JK_RESET:  w_next = 1'b0;
      JK_SET:    w_next = 1'b1;
      JK_TOGGLE: w_next = ~q;
      default:   w_next = q;
    endcase
    return w_next;
  endfunction

endpackage

// File: rtl/jk_flip_flop_bit.sv
// rtl/jk_flip_flop_bit.sv - single JK cell with async active-high reset and clock enable
module jk_ff_bit
  import jk_ff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic j,
  input  logic k,
  input  logic rst_val,
  output logic q
);

  logic r_q;
  jk_mode_t w_mode;

  assign w_mode = jk_mode_t'({j, k});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= rst_val;
    end else if (ce) begin
      r_q <= next_q(w_mode, r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_flip_flop.sv
// rtl/jk_flip_flop.sv - WIDTH-bit JK flip-flop bank; optional ce port under JK_FF_CE_EN
module jk_flip_flop
  import jk_ff_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef JK_FF_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  logic w_ce;

`ifdef JK_FF_CE_EN
  assign w_ce = ce;
`else
  assign w_ce = 1'b1;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_ff_bit u_bit (
      .clk     (clk),
      .rst     (rst),
      .ce      (w_ce),
      .j       (j[gi]),
      .k       (k[gi]),
      .rst_val (RESET_VAL[gi]),
      .q       (q[gi])
    );
  end

  // complement taken from the registered value so it tracks q through reset too
  assign q_n = ~q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// tb/tb_jk_flip_flop.sv - directed self-checking bench for jk_flip_flop (JK_FF_CE_EN optional)
module tb_jk_flip_flop;

  logic       clk;
  logic       rst, rst4, rst4s;
  logic [0:0] j1, k1, q1, qn1;
  logic [3:0] j4, k4, q4, qn4;
  logic [3:0] j4s, k4s, q4s, qn4s;
  logic       ce;
  int         checks;
  int         errors;

  jk_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk (clk),
    .rst (rst),
`ifdef JK_FF_CE_EN
    .ce  (ce),
`endif
    .j   (j1),
    .k   (k1),
    .q   (q1),
    .q_n (qn1)
  );

  jk_flip_flop #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (
    .clk (clk),
    .rst (rst4),
`ifdef JK_FF_CE_EN
    .ce  (1'b1),
`endif
    .j   (j4),
    .k   (k4),
    .q   (q4),
    .q_n (qn4)
  );

  jk_flip_flop #(.WIDTH(4), .RESET_VAL(4'hF)) dut4s (
    .clk (clk),
    .rst (rst4s),
`ifdef JK_FF_CE_EN
    .ce  (1'b1),
`endif
    .j   (j4s),
    .k   (k4s),
    .q   (q4s),
    .q_n (qn4s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    checks++;
    if (q1 !== 1'b0) begin errors++; $display("FAIL reset_q got=%b exp=0", q1); end
    checks++;
    if (qn1 !== 1'b1) begin errors++; $display("FAIL reset_qn got=%b exp=1", qn1); end
    checks++;
    if (q4s !== 4'hF) begin errors++; $display("FAIL reset_val_f got=%h exp=f", q4s); end
    checks++;
    if (qn4s !== 4'h0) begin errors++; $display("FAIL reset_val_f_qn got=%h exp=0", qn4s); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q1 !== 1'b0) begin errors++; $display("FAIL hold_after_reset got=%b exp=0", q1); end
  endtask

  task automatic test_reset_set();
    @(negedge clk); j1 = 1'b0; k1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b0) begin errors++; $display("FAIL jk01 got=%b exp=0", q1); end
    @(negedge clk); j1 = 1'b1; k1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b1) begin errors++; $display("FAIL jk10 got=%b exp=1", q1); end
    checks++;
    if (qn1 !== 1'b0) begin errors++; $display("FAIL jk10_qn got=%b exp=0", qn1); end
  endtask

  task automatic test_toggle();
    @(negedge clk); j1 = 1'b1; k1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b0) begin errors++; $display("FAIL toggle1 got=%b exp=0", q1); end
    // a mid-cycle j/k change must not reach q
    #1; j1 = 1'b1; k1 = 1'b0; #1;
    checks++;
    if (q1 !== 1'b0) begin errors++; $display("FAIL midcycle_jk got=%b exp=0", q1); end
    @(negedge clk); j1 = 1'b1; k1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b1) begin errors++; $display("FAIL toggle2 got=%b exp=1", q1); end
    @(negedge clk); j1 = 1'b0; k1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b1) begin errors++; $display("FAIL toggle_hold got=%b exp=1", q1); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #3;
    rst = 1'b1; #1;
    checks++;
    if (q1 !== 1'b0) begin errors++; $display("FAIL async_rst got=%b exp=0", q1); end
    checks++;
    if (qn1 !== 1'b1) begin errors++; $display("FAIL async_rst_qn got=%b exp=1", qn1); end
    @(negedge clk); j1 = 1'b1; k1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b0) begin errors++; $display("FAIL rst_over_edge got=%b exp=0", q1); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b1) begin errors++; $display("FAIL first_edge_after_rst got=%b exp=1", q1); end
    @(negedge clk); j1 = 1'b0; k1 = 1'b0; j4s = 4'h0; k4s = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (q4s !== 4'h0) begin errors++; $display("FAIL clear4 got=%h exp=0", q4s); end
    #2; rst4s = 1'b1; #1;
    checks++;
    if (q4s !== 4'hF) begin errors++; $display("FAIL async_rst4 got=%h exp=f", q4s); end
    @(negedge clk); rst4s = 1'b0; j4s = 4'h0; k4s = 4'h0;
  endtask

  task automatic test_vector();
    @(negedge clk); j4 = 4'b0101; k4 = 4'b1010;
    @(posedge clk); #1;
    checks++;
    if (q4 !== 4'b0101) begin errors++; $display("FAIL vec_load got=%b exp=0101", q4); end
    @(negedge clk); j4 = 4'b1100; k4 = 4'b1010;
    @(posedge clk); #1;
    // bit3 toggle, bit2 set, bit1 reset, bit0 hold
    checks++;
    if (q4 !== 4'b1101) begin errors++; $display("FAIL vec_mix got=%b exp=1101", q4); end
    checks++;
    if (qn4 !== 4'b0010) begin errors++; $display("FAIL vec_mix_qn got=%b exp=0010", qn4); end
  endtask

`ifdef JK_FF_CE_EN
  task automatic test_ce();
    @(negedge clk); j1 = 1'b0; k1 = 1'b1; ce = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b0) begin errors++; $display("FAIL ce_clear got=%b exp=0", q1); end
    @(negedge clk); j1 = 1'b1; k1 = 1'b0; ce = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b0) begin errors++; $display("FAIL ce_off got=%b exp=0", q1); end
    @(negedge clk); ce = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b1) begin errors++; $display("FAIL ce_on got=%b exp=1", q1); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    ce     = 1'b1;
    rst    = 1'b1; rst4 = 1'b1; rst4s = 1'b1;
    j1 = '0; k1 = '0; j4 = '0; k4 = '0; j4s = '0; k4s = '0;
    #2;
    rst = 1'b0; rst4 = 1'b0; rst4s = 1'b0;
    test_reset();
    test_reset_set();
    test_toggle();
    test_async_reset();
    test_vector();
`ifdef JK_FF_CE_EN
    test_ce();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
